// File: rtl/uart_fifo_mmio.sv
// uart_fifo_mmio: memory-mapped UART front end with TX/RX FIFOs.
// Bus side is a word-addressed, always-ready register port. Line side connects
// to a uart_lite instance.
//   clk, reset                       clock, synchronous active-high reset
//   cmd_valid/cmd_wr/cmd_addr/cmd_wdata   register access (0 DATA, 1 STATUS, 2 CTRL)
//   rsp_rdata                        read data, registered one cycle after the read
//   tx_rdy/tx_vld/tx_data            character handshake towards uart_lite
//   rx_valid/rx_data                 received-character strobe from uart_lite
//   irq                              registered level interrupt
module uart_fifo_mmio #(
  parameter int WL        = 32,
  parameter int DATA_BITS = 8,
  parameter int TX_DEPTH  = 16,
  parameter int RX_DEPTH  = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cmd_valid,
  input  logic                 cmd_wr,
  input  logic [1:0]           cmd_addr,
  input  logic [WL-1:0]        cmd_wdata,
  output logic [WL-1:0]        rsp_rdata,
  input  logic                 tx_rdy,
  output logic                 tx_vld,
  output logic [DATA_BITS-1:0] tx_data,
  input  logic                 rx_valid,
  input  logic [DATA_BITS-1:0] rx_data,
  output logic                 irq
);

  localparam int TXA = $clog2(TX_DEPTH);
  localparam int RXA = $clog2(RX_DEPTH);
  localparam logic [TXA:0] TX_CAP = (TXA+1)'(TX_DEPTH);
  localparam logic [RXA:0] RX_CAP = (RXA+1)'(RX_DEPTH);

  // state    | meaning
  // ST_IDLE  | waiting for tx_rdy with a queued character
  // ST_PULSE | tx_vld high for this cycle
  // ST_GUARD | covers uart_lite's tx_rdy deassert latency
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_PULSE = 2'd1;
  localparam logic [1:0] ST_GUARD = 2'd2;

  logic [1:0] state;

  logic [DATA_BITS-1:0] tx_mem [TX_DEPTH];
  logic [DATA_BITS-1:0] rx_mem [RX_DEPTH];
  logic [TXA-1:0] tx_wr, tx_rd;
  logic [RXA-1:0] rx_wr, rx_rd;
  logic [TXA:0]   tx_count;
  logic [RXA:0]   rx_count;
  logic tx_ovf, rx_ovf, rx_ie, tx_ie;

  logic wr_data, rd_data, wr_status, wr_ctrl, rd_any;
  logic tx_flush, rx_flush;
  logic tx_full, tx_empty, rx_full, rx_empty;
  logic tx_push, tx_pop, tx_drop, rx_push, rx_pop, rx_drop;
  logic [WL-1:0] rd_mux;
  logic unused_wdata;

  assign rd_any    = cmd_valid & ~cmd_wr;
  assign wr_data   = cmd_valid & cmd_wr & (cmd_addr == 2'd0);
  assign rd_data   = rd_any & (cmd_addr == 2'd0);
  assign wr_status = cmd_valid & cmd_wr & (cmd_addr == 2'd1);
  assign wr_ctrl   = cmd_valid & cmd_wr & (cmd_addr == 2'd2);
  assign tx_flush  = wr_ctrl & cmd_wdata[2];
  assign rx_flush  = wr_ctrl & cmd_wdata[3];
  assign unused_wdata = &{1'b0, cmd_wdata};

  assign tx_full  = (tx_count == TX_CAP);
  assign tx_empty = (tx_count == '0);
  assign rx_full  = (rx_count == RX_CAP);
  assign rx_empty = (rx_count == '0);

  // A flush discards the FIFO, so nothing may be popped or pushed that cycle.
  assign tx_pop  = (state == ST_IDLE) & tx_rdy & ~tx_empty & ~tx_flush;
  assign tx_push = wr_data & ~tx_flush & (~tx_full | tx_pop);
  assign tx_drop = wr_data & ~tx_flush & tx_full & ~tx_pop;
  assign rx_pop  = rd_data & ~rx_empty & ~rx_flush;
  assign rx_push = rx_valid & ~rx_flush & (~rx_full | rx_pop);
  assign rx_drop = rx_valid & ~rx_flush & rx_full & ~rx_pop;

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wr] <= cmd_wdata[DATA_BITS-1:0];
    if (rx_push) rx_mem[rx_wr] <= rx_data;
  end

  always_ff @(posedge clk) begin
    if (reset || tx_flush) begin
      tx_wr    <= '0;
      tx_rd    <= '0;
      tx_count <= '0;
    end else begin
      if (tx_push) tx_wr <= tx_wr + 1'b1;
      if (tx_pop)  tx_rd <= tx_rd + 1'b1;
      tx_count <= tx_count + (TXA+1)'(tx_push) - (TXA+1)'(tx_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (reset || rx_flush) begin
      rx_wr    <= '0;
      rx_rd    <= '0;
      rx_count <= '0;
    end else begin
      if (rx_push) rx_wr <= rx_wr + 1'b1;
      if (rx_pop)  rx_rd <= rx_rd + 1'b1;
      rx_count <= rx_count + (RXA+1)'(rx_push) - (RXA+1)'(rx_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      tx_vld  <= 1'b0;
      tx_data <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (tx_pop) begin
            tx_vld  <= 1'b1;
            tx_data <= tx_mem[tx_rd];
            state   <= ST_PULSE;
          end
        end
        ST_PULSE: begin
          tx_vld <= 1'b0;
          state  <= ST_GUARD;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Overflow set wins over a same-cycle W1C so a fresh drop is never lost.
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_ovf <= 1'b0;
      rx_ovf <= 1'b0;
      rx_ie  <= 1'b0;
      tx_ie  <= 1'b0;
      irq    <= 1'b0;
    end else begin
      if (wr_status && cmd_wdata[20]) tx_ovf <= 1'b0;
      if (wr_status && cmd_wdata[21]) rx_ovf <= 1'b0;
      if (tx_drop) tx_ovf <= 1'b1;
      if (rx_drop) rx_ovf <= 1'b1;
      if (wr_ctrl) begin
        rx_ie <= cmd_wdata[0];
        tx_ie <= cmd_wdata[1];
      end
      irq <= (rx_ie & ~rx_empty) | (tx_ie & tx_empty) | tx_ovf | rx_ovf;
    end
  end

  always_comb begin
    rd_mux = '0;
    case (cmd_addr)
      2'd0: begin
        if (!rx_empty) begin
          rd_mux[WL-1]          = 1'b1;
          rd_mux[DATA_BITS-1:0] = rx_mem[rx_rd];
        end
      end
      2'd1: begin
        rd_mux[7:0]  = 8'(tx_count);
        rd_mux[15:8] = 8'(rx_count);
        rd_mux[16]   = tx_full;
        rd_mux[17]   = tx_empty;
        rd_mux[18]   = rx_full;
        rd_mux[19]   = rx_empty;
        rd_mux[20]   = tx_ovf;
        rd_mux[21]   = rx_ovf;
      end
      2'd2: rd_mux[1:0] = {tx_ie, rx_ie};
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) rsp_rdata <= '0;
    else if (rd_any) rsp_rdata <= rd_mux;
  end

endmodule

// File: tb/tb_uart_fifo_mmio.sv
// tb_uart_fifo_mmio: self-checking bench for uart_fifo_mmio with a queue-based
// reference model of both FIFOs, the register map and the TX character stream.
module tb_uart_fifo_mmio;
  localparam int WL = 32;
  localparam int DB = 8;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_wr = 1'b0;
  logic [1:0]    cmd_addr = 2'd0;
  logic [WL-1:0] cmd_wdata = '0;
  logic [WL-1:0] rsp_rdata;
  logic          tx_rdy = 1'b0;
  logic          tx_vld;
  logic [DB-1:0] tx_data;
  logic          rx_valid = 1'b0;
  logic [DB-1:0] rx_data = '0;
  logic          irq;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  logic [7:0] sent[$];
  int sent_cyc[$];

  always #5 clk = ~clk;

  uart_fifo_mmio #(.WL(WL), .DATA_BITS(DB), .TX_DEPTH(DEPTH), .RX_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_wr(cmd_wr),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .rsp_rdata(rsp_rdata),
    .tx_rdy(tx_rdy), .tx_vld(tx_vld), .tx_data(tx_data),
    .rx_valid(rx_valid), .rx_data(rx_data), .irq(irq)
  );

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (tx_vld === 1'b1) begin
      sent.push_back(tx_data);
      sent_cyc.push_back(cyc);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] exp_status(int txc, int rxc, bit txo, bit rxo);
    logic [31:0] s;
    s = '0;
    s[7:0]  = 8'(txc);
    s[15:8] = 8'(rxc);
    s[16] = (txc == DEPTH);
    s[17] = (txc == 0);
    s[18] = (rxc == DEPTH);
    s[19] = (rxc == 0);
    s[20] = txo;
    s[21] = rxo;
    return s;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_cycle(input logic v, input logic w, input logic [1:0] a,
                           input logic [31:0] wd, input logic rv, input logic [7:0] rb,
                           output logic [31:0] rdata);
    cmd_valid = v; cmd_wr = w; cmd_addr = a; cmd_wdata = wd;
    rx_valid = rv; rx_data = rb;
    tick();
    cmd_valid = 1'b0; cmd_wr = 1'b0; rx_valid = 1'b0;
    rdata = rsp_rdata;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] wd);
    logic [31:0] dummy;
    bus_cycle(1'b1, 1'b1, a, wd, 1'b0, 8'h00, dummy);
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] r);
    bus_cycle(1'b1, 1'b0, a, 32'h0, 1'b0, 8'h00, r);
  endtask

  task automatic rx_push(input logic [7:0] b);
    logic [31:0] dummy;
    bus_cycle(1'b0, 1'b0, 2'd0, 32'h0, 1'b1, b, dummy);
  endtask

  task automatic wait_sent(input int n);
    for (int i = 0; i < 400 && sent.size() < n; i++) tick();
    repeat (6) tick();
  endtask

  task automatic test_reset();
    logic [31:0] r;
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    n_cmp++; if (tx_vld !== 1'b0) begin n_bad++; $display("FAIL reset_tx_vld: got %b want 0", tx_vld); end
    n_cmp++; if (tx_data !== 8'h00) begin n_bad++; $display("FAIL reset_tx_data: got %h want 00", tx_data); end
    n_cmp++; if (rsp_rdata !== 32'h0) begin n_bad++; $display("FAIL reset_rdata: got %h want 0", rsp_rdata); end
    n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL reset_irq: got %b want 0", irq); end
    bus_read(2'd1, r);
    n_cmp++; if (r !== 32'h000A_0000) begin n_bad++; $display("FAIL reset_status: got %h want 000a0000", r); end
  endtask

  task automatic test_tx_basic();
    logic [31:0] r;
    logic [7:0] exp3 [3];
    exp3[0] = 8'h41; exp3[1] = 8'h42; exp3[2] = 8'h43;
    tx_rdy = 1'b1;
    sent.delete(); sent_cyc.delete();
    for (int i = 0; i < 3; i++) bus_write(2'd0, {24'h0, exp3[i]});
    wait_sent(3);
    n_cmp++; if (sent.size() != 3) begin n_bad++; $display("FAIL tx_basic_count: got %0d want 3", sent.size()); end
    for (int i = 0; i < 3; i++) begin
      if (i < sent.size()) begin
        n_cmp++; if (sent[i] !== exp3[i]) begin n_bad++; $display("FAIL tx_basic_char%0d: got %h want %h", i, sent[i], exp3[i]); end
      end
    end
    for (int i = 1; i < sent_cyc.size(); i++) begin
      n_cmp++; if (sent_cyc[i] - sent_cyc[i-1] < 3) begin n_bad++; $display("FAIL tx_spacing: got %0d want >=3", sent_cyc[i] - sent_cyc[i-1]); end
    end
    bus_read(2'd1, r);
    n_cmp++; if (r !== 32'h000A_0000) begin n_bad++; $display("FAIL tx_basic_status: got %h want 000a0000", r); end
  endtask

  task automatic test_tx_overflow();
    logic [31:0] r, wd;
    logic [7:0] ch[$];
    tx_rdy = 1'b0;
    repeat (4) tick();
    sent.delete(); sent_cyc.delete();
    for (int i = 0; i < 17; i++) begin
      wd = $urandom;
      ch.push_back(wd[7:0]);
      bus_write(2'd0, wd);
    end
    bus_read(2'd1, r);
    n_cmp++; if (r !== exp_status(16, 0, 1'b1, 1'b0)) begin n_bad++; $display("FAIL tx_ovf_status: got %h want %h", r, exp_status(16, 0, 1'b1, 1'b0)); end
    n_cmp++; if (irq !== 1'b1) begin n_bad++; $display("FAIL tx_ovf_irq: got %b want 1", irq); end
    tx_rdy = 1'b1;
    wait_sent(16);
    n_cmp++; if (sent.size() != 16) begin n_bad++; $display("FAIL tx_ovf_sent: got %0d want 16", sent.size()); end
    for (int i = 0; i < 16 && i < sent.size(); i++) begin
      n_cmp++; if (sent[i] !== ch[i]) begin n_bad++; $display("FAIL tx_ovf_char%0d: got %h want %h", i, sent[i], ch[i]); end
    end
    bus_write(2'd1, 32'h0010_0000);
    bus_read(2'd1, r);
    n_cmp++; if (r !== 32'h000A_0000) begin n_bad++; $display("FAIL tx_ovf_w1c: got %h want 000a0000", r); end
    n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL tx_ovf_irq_clear: got %b want 0", irq); end
  endtask

  task automatic test_rx_read();
    logic [31:0] r;
    logic [31:0] exp4 [4];
    exp4[0] = 32'h8000_0010; exp4[1] = 32'h8000_0020;
    exp4[2] = 32'h8000_0030; exp4[3] = 32'h0000_0000;
    rx_push(8'h10); rx_push(8'h20); rx_push(8'h30);
    for (int i = 0; i < 4; i++) begin
      bus_read(2'd0, r);
      n_cmp++; if (r !== exp4[i]) begin n_bad++; $display("FAIL rx_read%0d: got %h want %h", i, r, exp4[i]); end
    end
  endtask

  task automatic test_rx_overflow_irq();
    logic [31:0] r;
    logic [7:0] b[$];
    logic [7:0] v;
    bus_write(2'd2, 32'h1);
    for (int i = 0; i < 17; i++) begin
      v = 8'($urandom);
      b.push_back(v);
      rx_push(v);
      if (i == 0) begin
        n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL rx_irq_lag: got %b want 0", irq); end
      end
      if (i == 1) begin
        n_cmp++; if (irq !== 1'b1) begin n_bad++; $display("FAIL rx_irq_set: got %b want 1", irq); end
      end
    end
    bus_read(2'd1, r);
    n_cmp++; if (r !== exp_status(0, 16, 1'b0, 1'b1)) begin n_bad++; $display("FAIL rx_ovf_status: got %h want %h", r, exp_status(0, 16, 1'b0, 1'b1)); end
    bus_write(2'd1, 32'h0020_0000);
    bus_read(2'd1, r);
    n_cmp++; if (r !== exp_status(0, 16, 1'b0, 1'b0)) begin n_bad++; $display("FAIL rx_ovf_w1c: got %h want %h", r, exp_status(0, 16, 1'b0, 1'b0)); end
    for (int i = 0; i < 16; i++) begin
      bus_read(2'd0, r);
      n_cmp++; if (r !== (32'h8000_0000 | 32'(b[i]))) begin n_bad++; $display("FAIL rx_ovf_data%0d: got %h want %h", i, r, 32'h8000_0000 | 32'(b[i])); end
    end
    tick(); tick();
    n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL rx_irq_drained: got %b want 0", irq); end
    bus_write(2'd2, 32'h0);
  endtask

  task automatic test_rx_full_simul();
    logic [31:0] r;
    logic [7:0] q[$];
    logic [7:0] v;
    for (int i = 0; i < 16; i++) begin
      v = 8'($urandom);
      q.push_back(v);
      rx_push(v);
    end
    v = 8'($urandom);
    bus_cycle(1'b1, 1'b0, 2'd0, 32'h0, 1'b1, v, r);
    n_cmp++; if (r !== (32'h8000_0000 | 32'(q[0]))) begin n_bad++; $display("FAIL rx_simul_head: got %h want %h", r, 32'h8000_0000 | 32'(q[0])); end
    void'(q.pop_front());
    q.push_back(v);
    bus_read(2'd1, r);
    n_cmp++; if (r !== exp_status(0, 16, 1'b0, 1'b0)) begin n_bad++; $display("FAIL rx_simul_status: got %h want %h", r, exp_status(0, 16, 1'b0, 1'b0)); end
    for (int i = 0; i < 16; i++) begin
      bus_read(2'd0, r);
      n_cmp++; if (r !== (32'h8000_0000 | 32'(q[i]))) begin n_bad++; $display("FAIL rx_simul_order%0d: got %h want %h", i, r, 32'h8000_0000 | 32'(q[i])); end
    end
    for (int i = 0; i < 3; i++) rx_push(8'($urandom));
    bus_write(2'd2, 32'h8);
    bus_read(2'd1, r);
    n_cmp++; if (r !== 32'h000A_0000) begin n_bad++; $display("FAIL rx_flush_status: got %h want 000a0000", r); end
    bus_read(2'd2, r);
    n_cmp++; if (r !== 32'h0) begin n_bad++; $display("FAIL ctrl_selfclear: got %h want 0", r); end
  endtask

  task automatic test_reset_midflight();
    logic [31:0] r;
    bit found;
    int n0;
    tx_rdy = 1'b0;
    for (int i = 0; i < 6; i++) bus_write(2'd0, $urandom);
    tx_rdy = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      if (tx_vld === 1'b1) found = 1'b1;
    end
    n_cmp++; if (!found) begin n_bad++; $display("FAIL midflight_pulse: got none want tx_vld"); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_cmp++; if (tx_vld !== 1'b0) begin n_bad++; $display("FAIL midflight_vld: got %b want 0", tx_vld); end
    n0 = sent.size();
    bus_read(2'd1, r);
    n_cmp++; if (r !== 32'h000A_0000) begin n_bad++; $display("FAIL midflight_status: got %h want 000a0000", r); end
    repeat (20) tick();
    n_cmp++; if (sent.size() != n0) begin n_bad++; $display("FAIL midflight_resend: got %0d want %0d", sent.size(), n0); end
  endtask

  task automatic test_random();
    logic [7:0] txq[$];
    logic [7:0] rxq[$];
    bit txo, rxo, rv, do_wr, do_rd, pop;
    int op;
    logic [7:0] rb;
    logic [31:0] wd, r, expr;
    for (int it = 0; it < 4; it++) begin
      tx_rdy = 1'b0;
      bus_write(2'd2, 32'hC);
      bus_write(2'd1, 32'h0030_0000);
      txq.delete(); rxq.delete(); txo = 1'b0; rxo = 1'b0;
      sent.delete(); sent_cyc.delete();
      for (int c = 0; c < 48; c++) begin
        op = $urandom_range(0, 3);
        rv = 1'($urandom_range(0, 1));
        rb = 8'($urandom);
        wd = $urandom;
        do_wr = (op == 0);
        do_rd = (op == 1);
        pop = do_rd && (rxq.size() > 0);
        expr = pop ? (32'h8000_0000 | 32'(rxq[0])) : 32'h0;
        if (do_wr) begin
          if (txq.size() < DEPTH) txq.push_back(wd[7:0]);
          else txo = 1'b1;
        end
        if (pop) void'(rxq.pop_front());
        if (rv) begin
          if (rxq.size() < DEPTH) rxq.push_back(rb);
          else rxo = 1'b1;
        end
        bus_cycle(do_wr | do_rd, do_wr, 2'd0, wd, rv, rb, r);
        if (do_rd) begin
          n_cmp++; if (r !== expr) begin n_bad++; $display("FAIL rand_read it%0d c%0d: got %h want %h", it, c, r, expr); end
        end
      end
      bus_read(2'd1, r);
      expr = exp_status(txq.size(), rxq.size(), txo, rxo);
      n_cmp++; if (r !== expr) begin n_bad++; $display("FAIL rand_status it%0d: got %h want %h", it, r, expr); end
      tx_rdy = 1'b1;
      wait_sent(txq.size());
      n_cmp++; if (sent.size() != txq.size()) begin n_bad++; $display("FAIL rand_tx_count it%0d: got %0d want %0d", it, sent.size(), txq.size()); end
      for (int i = 0; i < txq.size() && i < sent.size(); i++) begin
        n_cmp++; if (sent[i] !== txq[i]) begin n_bad++; $display("FAIL rand_tx_char it%0d/%0d: got %h want %h", it, i, sent[i], txq[i]); end
      end
      while (rxq.size() > 0) begin
        bus_read(2'd0, r);
        expr = 32'h8000_0000 | 32'(rxq.pop_front());
        n_cmp++; if (r !== expr) begin n_bad++; $display("FAIL rand_rx_drain it%0d: got %h want %h", it, r, expr); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_tx_basic();
    test_tx_overflow();
    test_rx_read();
    test_rx_overflow_irq();
    test_rx_full_simul();
    test_reset_midflight();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
